alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage_pkg.sv | 18 +
 rtl/alu_operand_stage_if.sv | 40 ++++
 rtl/fwd_resolve.sv | 29 ++
 rtl/alu_operand_stage.sv | 82 ++++++++
 tb/tb_alu_operand_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared constants and operand-select encodings for the ALU operand stage.
package alu_operand_stage_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_W        = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        SRC_A_RS1 = 1'b0,
        SRC_A_PC  = 1'b1
    } alusrc_a_e;

    typedef enum logic {
        SRC_B_RS2 = 1'b0,
        SRC_B_IMM = 1'b1
    } alusrc_b_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-to-ALU handshake bundle: decoded operands, forwarding sources and registered results.
interface alu_operand_stage_if
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NFWD = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [REG_W-1:0]        rs1_addr;
    logic [REG_W-1:0]        rs2_addr;
    logic [XLEN-1:0]         output_data1;
    logic [XLEN-1:0]         output_data2;
    logic [XLEN-1:0]         imm_val;
    logic [XLEN-1:0]         pc;
    logic                    alusrc_a;
    logic                    alusrc;
    logic [NFWD-1:0]         fwd_valid;
    logic [REG_W*NFWD-1:0]   fwd_rd;
    logic [XLEN*NFWD-1:0]    fwd_data;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         op_a;
    logic [XLEN-1:0]         op_b;
    logic [XLEN-1:0]         store_data;

    modport master (
        output in_valid, rs1_addr, rs2_addr, output_data1, output_data2, imm_val, pc,
               alusrc_a, alusrc, fwd_valid, fwd_rd, fwd_data, flush, out_ready,
        input  in_ready, out_valid, op_a, op_b, store_data
    );

    modport slave (
        input  in_valid, rs1_addr, rs2_addr, output_data1, output_data2, imm_val, pc,
               alusrc_a, alusrc, fwd_valid, fwd_rd, fwd_data, flush, out_ready,
        output in_ready, out_valid, op_a, op_b, store_data
    );

endinterface

// File: rtl/fwd_resolve.sv
// Priority forwarding for one source operand: youngest matching source wins, x0 never forwarded.
module fwd_resolve
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NFWD = 2
) (
    input  logic [REG_W-1:0]      rs_addr,
    input  logic [XLEN-1:0]       rf_data,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [REG_W*NFWD-1:0] fwd_rd,
    input  logic [XLEN*NFWD-1:0]  fwd_data,
    output logic [XLEN-1:0]       value,
    output logic                  hit
);

    // Walk oldest to youngest so the lowest matching index is the final assignment.
    always_comb begin
        value = rf_data;
        hit   = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_rd[REG_W*i +: REG_W] == rs_addr) && (rs_addr != REG_ZERO)) begin
                value = fwd_data[XLEN*i +: XLEN];
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage: resolves forwarded sources, selects ALU operands and registers them behind a valid/ready handshake.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NFWD = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_operand_stage_if.slave bus,
    output logic [CNTW-1:0]   fwd_count
);

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            load;
    logic            fwd_used;

    logic            out_valid_q;
    logic [XLEN-1:0] op_a_q;
    logic [XLEN-1:0] op_b_q;
    logic [XLEN-1:0] store_data_q;
    logic [CNTW-1:0] fwd_count_q;

    fwd_resolve #(.XLEN(XLEN), .NFWD(NFWD)) u_rs1 (
        .rs_addr   (bus.rs1_addr),
        .rf_data   (bus.output_data1),
        .fwd_valid (bus.fwd_valid),
        .fwd_rd    (bus.fwd_rd),
        .fwd_data  (bus.fwd_data),
        .value     (rs1_val),
        .hit       (rs1_hit)
    );

    fwd_resolve #(.XLEN(XLEN), .NFWD(NFWD)) u_rs2 (
        .rs_addr   (bus.rs2_addr),
        .rf_data   (bus.output_data2),
        .fwd_valid (bus.fwd_valid),
        .fwd_rd    (bus.fwd_rd),
        .fwd_data  (bus.fwd_data),
        .value     (rs2_val),
        .hit       (rs2_hit)
    );

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready;

    // rs2 always reaches store_data, so any rs2 forward counts; rs1 only when op_a actually uses it.
    assign fwd_used = (rs1_hit && (bus.alusrc_a == SRC_A_RS1)) || rs2_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            store_data_q <= '0;
            fwd_count_q  <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q  <= 1'b1;
            op_a_q       <= (bus.alusrc_a == SRC_A_PC)  ? bus.pc      : rs1_val;
            op_b_q       <= (bus.alusrc   == SRC_B_IMM) ? bus.imm_val : rs2_val;
            store_data_q <= rs2_val;
            if (fwd_used && (fwd_count_q != '1)) begin
                fwd_count_q <= fwd_count_q + CNTW'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.op_a       = op_a_q;
    assign bus.op_b       = op_b_q;
    assign bus.store_data = store_data_q;
    assign fwd_count      = fwd_count_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and random checks of alu_operand_stage against a transaction-level model; a CNTW=2 twin covers saturation.
module tb_alu_operand_stage;

    localparam int XLEN = 32;
    localparam int NFWD = 2;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] fwd_count;
    logic [1:0]  fwd_count_sat;

    always #5 clk = ~clk;

    alu_operand_stage_if #(.XLEN(XLEN), .NFWD(NFWD)) bus ();
    alu_operand_stage_if #(.XLEN(XLEN), .NFWD(NFWD)) bus_sat ();

    assign bus_sat.in_valid     = bus.in_valid;
    assign bus_sat.rs1_addr     = bus.rs1_addr;
    assign bus_sat.rs2_addr     = bus.rs2_addr;
    assign bus_sat.output_data1 = bus.output_data1;
    assign bus_sat.output_data2 = bus.output_data2;
    assign bus_sat.imm_val      = bus.imm_val;
    assign bus_sat.pc           = bus.pc;
    assign bus_sat.alusrc_a     = bus.alusrc_a;
    assign bus_sat.alusrc       = bus.alusrc;
    assign bus_sat.fwd_valid    = bus.fwd_valid;
    assign bus_sat.fwd_rd       = bus.fwd_rd;
    assign bus_sat.fwd_data     = bus.fwd_data;
    assign bus_sat.flush        = bus.flush;
    assign bus_sat.out_ready    = bus.out_ready;

    alu_operand_stage #(.XLEN(XLEN), .NFWD(NFWD), .CNTW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .fwd_count (fwd_count)
    );

    alu_operand_stage #(.XLEN(XLEN), .NFWD(NFWD), .CNTW(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_sat.slave),
        .fwd_count (fwd_count_sat)
    );

    int checks = 0;
    int failures = 0;

    // Forwarding sources as the bench sees them; packed onto the bus by drive_fwd.
    bit          fv  [NFWD];
    logic [4:0]  frd [NFWD];
    logic [31:0] fd  [NFWD];

    // Transaction-level expectation of what the stage holds.
    bit          m_valid;
    logic [31:0] m_a, m_b, m_sd;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fwd();
        for (int i = 0; i < NFWD; i++) begin
            bus.fwd_valid[i]           = fv[i];
            bus.fwd_rd[5*i +: 5]       = frd[i];
            bus.fwd_data[XLEN*i +: XLEN] = fd[i];
        end
    endtask

    function automatic logic [31:0] ref_resolve(input logic [4:0] addr, input logic [31:0] rf, output bit hit);
        hit = 1'b0;
        if (addr == 5'd0) return rf;
        for (int i = 0; i < NFWD; i++) begin
            if (fv[i] && frd[i] == addr) begin
                hit = 1'b1;
                return fd[i];
            end
        end
        return rf;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // One clock: check in_ready, predict the edge, then compare registered outputs.
    task automatic cycle();
        logic [31:0] r1, r2;
        bit h1, h2, ready;
        #1;
        ready = !m_valid || bus.out_ready;
        chk("in_ready", bus.in_ready, ready);
        r1 = ref_resolve(bus.rs1_addr, bus.output_data1, h1);
        r2 = ref_resolve(bus.rs2_addr, bus.output_data2, h2);
        if (rst) begin
            m_valid = 1'b0; m_a = '0; m_b = '0; m_sd = '0; m_cnt = 0;
        end else if (bus.flush) begin
            m_valid = 1'b0;
        end else if (bus.in_valid && ready) begin
            m_valid = 1'b1;
            m_a  = bus.alusrc_a ? bus.pc : r1;
            m_b  = bus.alusrc ? bus.imm_val : r2;
            m_sd = r2;
            if ((h1 && !bus.alusrc_a) || h2) m_cnt++;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", bus.out_valid, m_valid);
        chk("fwd_count", fwd_count, sat(m_cnt, 65535));
        chk("fwd_count_sat", fwd_count_sat, sat(m_cnt, 3));
        if (m_valid) begin
            chk("op_a", bus.op_a, m_a);
            chk("op_b", bus.op_b, m_b);
            chk("store_data", bus.store_data, m_sd);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        bus.rs1_addr = '0; bus.rs2_addr = '0;
        bus.output_data1 = '0; bus.output_data2 = '0;
        bus.imm_val = '0; bus.pc = '0; bus.alusrc_a = 1'b0; bus.alusrc = 1'b0;
        for (int i = 0; i < NFWD; i++) begin fv[i] = 1'b0; frd[i] = '0; fd[i] = '0; end
        drive_fwd();
    endtask

    initial begin
        m_valid = 1'b0; m_a = '0; m_b = '0; m_sd = '0; m_cnt = 0;
        idle_inputs();

        // Reset with an instruction presented: it must be discarded.
        rst = 1'b1; bus.in_valid = 1'b1; bus.rs1_addr = 5'd3; bus.output_data1 = 32'h1234;
        cycle(); cycle();
        chk("rst_out_valid", bus.out_valid, 32'd0);
        chk("rst_op_a", bus.op_a, 32'd0);
        chk("rst_op_b", bus.op_b, 32'd0);
        chk("rst_store_data", bus.store_data, 32'd0);
        chk("rst_fwd_count", fwd_count, 32'd0);
        idle_inputs();
        cycle();

        // No hazard.
        bus.in_valid = 1'b1; bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd6;
        bus.output_data1 = 32'h10; bus.output_data2 = 32'h20;
        cycle();
        chk("nohaz_op_a", bus.op_a, 32'h10);
        chk("nohaz_op_b", bus.op_b, 32'h20);
        chk("nohaz_fwd_count", fwd_count, 32'd0);

        // Youngest source wins.
        bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd9; bus.output_data1 = 32'h1; bus.output_data2 = 32'h2;
        fv[0] = 1'b1; frd[0] = 5'd7; fd[0] = 32'hAAAA;
        fv[1] = 1'b1; frd[1] = 5'd7; fd[1] = 32'hBBBB;
        drive_fwd();
        cycle();
        chk("prio_op_a", bus.op_a, 32'hAAAA);
        chk("prio_fwd_count", fwd_count, 32'd1);

        // x0 never forwarded; immediate on op_b, store_data keeps register-file value.
        bus.rs1_addr = 5'd4; bus.rs2_addr = 5'd0; bus.output_data2 = 32'h5555;
        bus.alusrc = 1'b1; bus.imm_val = 32'h4;
        fv[0] = 1'b1; frd[0] = 5'd0; fd[0] = 32'hFFFF; fv[1] = 1'b0;
        drive_fwd();
        cycle();
        chk("x0_op_b", bus.op_b, 32'h4);
        chk("x0_store_data", bus.store_data, 32'h5555);
        chk("x0_fwd_count", fwd_count, 32'd1);

        // Stall: load one forwarded instruction, then hold with changing forwards.
        bus.alusrc = 1'b0; bus.rs1_addr = 5'd8; bus.rs2_addr = 5'd8;
        fv[0] = 1'b1; frd[0] = 5'd8; fd[0] = 32'hCAFE0001;
        drive_fwd();
        cycle();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fd[0] = $urandom; fd[1] = $urandom; fv[1] = 1'b1; frd[1] = 5'd8;
            drive_fwd();
            cycle();
            chk("stall_in_ready", bus.in_ready, 32'd0);
            chk("stall_op_a", bus.op_a, 32'hCAFE0001);
            chk("stall_store_data", bus.store_data, 32'hCAFE0001);
        end
        bus.flush = 1'b1;
        cycle();
        chk("flush_out_valid", bus.out_valid, 32'd0);
        chk("flush_fwd_count", fwd_count, 32'd2);
        idle_inputs();
        cycle();

        // Random traffic with a small register range to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.rs1_addr = 5'($urandom_range(0, 3));
            bus.rs2_addr = 5'($urandom_range(0, 3));
            bus.output_data1 = $urandom; bus.output_data2 = $urandom;
            bus.imm_val = $urandom; bus.pc = $urandom;
            bus.alusrc_a = 1'($urandom_range(0, 1));
            bus.alusrc = 1'($urandom_range(0, 1));
            for (int i = 0; i < NFWD; i++) begin
                fv[i] = 1'($urandom_range(0, 1)); frd[i] = 5'($urandom_range(0, 3)); fd[i] = $urandom;
            end
            drive_fwd();
            cycle();
        end

        // Saturation of the 2-bit counter after a clean reset.
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.rs1_addr = 5'd2; bus.output_data1 = 32'h99;
        fv[1] = 1'b1; frd[1] = 5'd2;
        for (int k = 0; k < 5; k++) begin
            fd[1] = 32'h100 + k;
            drive_fwd();
            cycle();
        end
        chk("sat_fwd_count_w2", fwd_count_sat, 32'd3);
        chk("sat_fwd_count_w16", fwd_count, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
